// File: rtl/microwave_controller.sv
// microwave_controller
//   Sequencing controller for the microwave countdown timer (three BCD digits
//   m:t:o). It turns keypad/start/stop/door events into timer load, clear and
//   enable controls, and drives the magnetron enable and the end-of-cook beep.
//
// Parameters
//   BEEP_CYCLES   cycles beep stays high in DONE (>= 1)
//
// Ports
//   clock         system clock, rising edge
//   clr           synchronous active-high reset
//   tick_1hz      one-cycle pulse per second
//   key_valid     one-cycle pulse, keypad key present
//   key_code[3:0] key value, 0-9 digits, 10-15 ignored
//   start, stop   one-cycle pulses
//   door_closed   level, 1 = door closed
//   timer_zero    zero flag from the timer
//   timer_data    digit presented to the timer (registered)
//   timer_loadn   active-low load/shift strobe (registered)
//   timer_clrn    active-low timer clear (registered pulse, forced low by clr)
//   timer_enable  countdown enable (combinational)
//   mag_on, beep  magnetron enable / end-of-cook indicator (registered)
//   state[2:0]    IDLE=0 ENTRY=1 COOKING=2 PAUSED=3 DONE=4 QLOAD=5
//   digits[1:0]   number of digits entered
//
// Build option
//   QUICK_START_EN  start in IDLE with the door closed loads 0:30 and cooks.
module microwave_controller #(
  parameter int BEEP_CYCLES = 4
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] timer_data,
  output logic       timer_loadn,
  output logic       timer_clrn,
  output logic       timer_enable,
  output logic       mag_on,
  output logic       beep,
  output logic [2:0] state,
  output logic [1:0] digits
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_COOKING = 3'd2,
    S_PAUSED  = 3'd3,
    S_DONE    = 3'd4,
    S_QLOAD   = 3'd5
  } state_t;

  localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

  state_t        st;
  logic [BW-1:0] beep_cnt;
  logic          clrn_q;
  logic          qs_go;
  logic          entry_go;
  logic          key_take;
`ifdef QUICK_START_EN
  logic          q_step;   // 0: second load pending, 1: loads done
`endif

  assign state      = st;
  assign timer_clrn = clrn_q & ~clr;
  // Gate combinationally so a second cancelled by stop or door never counts.
  assign timer_enable = (st == S_COOKING) & tick_1hz & door_closed & ~stop;

`ifdef QUICK_START_EN
  assign qs_go = start & door_closed;
`else
  assign qs_go = 1'b0;
`endif

  // A zero timer (e.g. "0","0") must not start cooking.
  assign entry_go = start & door_closed & ~timer_zero;

  // Key acceptance, after the higher-priority events of the current state.
  always_comb begin
    key_take = 1'b0;
    if (key_valid && key_code <= 4'd9 && digits != 2'd3) begin
      case (st)
        S_IDLE:  key_take = ~qs_go;
        S_ENTRY: key_take = ~stop & ~entry_go;
        S_DONE:  key_take = ~stop;
        default: key_take = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      st          <= S_IDLE;
      digits      <= 2'd0;
      timer_data  <= 4'd0;
      timer_loadn <= 1'b1;
      clrn_q      <= 1'b1;
      mag_on      <= 1'b0;
      beep        <= 1'b0;
      beep_cnt    <= '0;
`ifdef QUICK_START_EN
      q_step      <= 1'b0;
`endif
    end else begin
      timer_loadn <= 1'b1;
      clrn_q      <= 1'b1;
      if (key_take) begin
        // Also ends DONE early: beep drops as the key is taken.
        st          <= S_ENTRY;
        digits      <= digits + 2'd1;
        timer_loadn <= 1'b0;
        timer_data  <= key_code;
        beep        <= 1'b0;
      end else begin
        case (st)
          S_IDLE: begin
`ifdef QUICK_START_EN
            if (qs_go) begin
              st          <= S_QLOAD;
              timer_loadn <= 1'b0;
              timer_data  <= 4'd3;
              q_step      <= 1'b0;
            end
`endif
          end
          S_ENTRY: begin
            if (stop) begin
              st     <= S_IDLE;
              clrn_q <= 1'b0;
              digits <= 2'd0;
            end else if (entry_go) begin
              st     <= S_COOKING;
              mag_on <= 1'b1;
            end
          end
          S_COOKING: begin
            if (timer_zero) begin
              st       <= S_DONE;
              mag_on   <= 1'b0;
              beep     <= 1'b1;
              beep_cnt <= '0;
              digits   <= 2'd0;
            end else if (stop || !door_closed) begin
              st     <= S_PAUSED;
              mag_on <= 1'b0;
            end
          end
          S_PAUSED: begin
            if (stop) begin
              st     <= S_IDLE;
              clrn_q <= 1'b0;
              digits <= 2'd0;
            end else if (start && door_closed) begin
              st     <= S_COOKING;
              mag_on <= 1'b1;
            end
          end
          S_DONE: begin
            if (stop || beep_cnt == BEEP_LAST) begin
              st   <= S_IDLE;
              beep <= 1'b0;
            end else begin
              beep_cnt <= beep_cnt + 1'b1;
            end
          end
`ifdef QUICK_START_EN
          S_QLOAD: begin
            // Stop is deliberately ignored until the 0:30 load completes.
            if (!q_step) begin
              timer_loadn <= 1'b0;
              timer_data  <= 4'd0;
              q_step      <= 1'b1;
            end else begin
              st     <= S_COOKING;
              mag_on <= 1'b1;
              digits <= 2'd2;
            end
          end
`endif
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_microwave_controller.sv
// Bench for microwave_controller: a behavioural BCD timer closes the loop on
// timer_zero; expectations come from cook-time arithmetic (m*60+t*10+o ticks),
// key counts and beep length.
module tb_microwave_controller;
  localparam int BEEP = 4;

  logic       clock = 1'b0;
  logic       clr, tick_1hz, key_valid, start, stop, door_closed, timer_zero;
  logic [3:0] key_code, timer_data;
  logic       timer_loadn, timer_clrn, timer_enable, mag_on, beep;
  logic [2:0] state;
  logic [1:0] digits;

  int n_chk = 0;
  int n_err = 0;

  microwave_controller #(.BEEP_CYCLES(BEEP)) dut (
    .clock(clock), .clr(clr), .tick_1hz(tick_1hz), .key_valid(key_valid),
    .key_code(key_code), .start(start), .stop(stop), .door_closed(door_closed),
    .timer_zero(timer_zero), .timer_data(timer_data), .timer_loadn(timer_loadn),
    .timer_clrn(timer_clrn), .timer_enable(timer_enable), .mag_on(mag_on),
    .beep(beep), .state(state), .digits(digits)
  );

  always #5 clock = ~clock;

  // Timer model: three BCD digits, shift-load, clear, countdown.
  logic [3:0] tm_m = 0, tm_t = 0, tm_o = 0;
  assign timer_zero = (tm_m == 0) && (tm_t == 0) && (tm_o == 0);
  always @(posedge clock) begin
    if (timer_clrn === 1'b0) begin
      tm_m <= 0; tm_t <= 0; tm_o <= 0;
    end else if (timer_loadn === 1'b0) begin
      tm_m <= tm_t; tm_t <= tm_o; tm_o <= timer_data;
    end else if (timer_enable === 1'b1 && !timer_zero) begin
      if (tm_o != 0) tm_o <= tm_o - 1;
      else begin
        tm_o <= 9;
        if (tm_t != 0) tm_t <= tm_t - 1;
        else begin tm_t <= 5; tm_m <= tm_m - 1; end
      end
    end
  end
  function automatic int secs();
    return tm_m * 60 + tm_t * 10 + tm_o;
  endfunction

  // Observers: every load strobe's data, and beep-high cycles.
  logic [3:0] loads[$];
  int beep_seen = 0;
  always @(posedge clock) if (timer_loadn === 1'b0) loads.push_back(timer_data);
  always @(negedge clock) if (beep === 1'b1) beep_seen++;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic press(input int code, input int exp_dig, input bit exp_load);
    key_valid = 1; key_code = 4'(code);
    step();
    key_valid = 0;
    chk("load_strobe", timer_loadn, exp_load ? 0 : 1);
    if (exp_load) chk("load_data", timer_data, code);
    chk("digits", digits, exp_dig);
    step();
    chk("load_release", timer_loadn, 1);
  endtask

  task automatic pulse_stop_to_idle();
    stop = 1; step(); stop = 0;
    chk("stop_clrn", timer_clrn, 0);
    chk("stop_state", state, 0);
    chk("stop_digits", digits, 0);
    step();
    chk("clrn_one_cycle", timer_clrn, 1);
    chk("timer_cleared", secs(), 0);
  endtask

  task automatic cook_ticks(input int gap, output int n);
    n = 0;
    while (state == 3'd2 && n < 700) begin
      tick_1hz = 1; step(); tick_1hz = 0; n++;
      repeat (gap) step();
    end
  endtask

  // Enter n digits (m:t:o right-aligned), start, count down, watch DONE.
  task automatic run_cook(input int n, input int m, input int t, input int o, input int gap);
    int typed[3];
    int base, ticks, b0, total;
    typed[0] = m; typed[1] = t; typed[2] = o;
    total = (n == 3 ? m * 60 : 0) + (n >= 2 ? t * 10 : 0) + o;
    base = loads.size();
    for (int i = 3 - n; i < 3; i++) press(typed[i], i - (3 - n) + 1, 1);
    start = 1; step(); start = 0;
    chk("cook_state", state, 2);
    chk("cook_mag", mag_on, 1);
    chk("load_count", loads.size() - base, n);
    for (int i = 0; i < n && base + i < loads.size(); i++)
      chk("load_seq", loads[base + i], typed[3 - n + i]);
    b0 = beep_seen;
    cook_ticks(gap, ticks);
    chk("ticks_to_done", ticks, total);
    chk("done_state", state, 4);
    chk("done_beep", beep, 1);
    chk("done_mag", mag_on, 0);
    for (int i = 0; i < 20 && state != 3'd0; i++) step();
    chk("back_idle", state, 0);
    chk("beep_cycles", beep_seen - b0, BEEP);
    chk("idle_digits", digits, 0);
  endtask

  initial begin
    int n;
    clr = 1; tick_1hz = 0; key_valid = 0; key_code = 0; start = 0; stop = 0;
    door_closed = 1;
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_digits", digits, 0);
    chk("rst_data", timer_data, 0);
    chk("rst_loadn", timer_loadn, 1);
    chk("rst_mag", mag_on, 0);
    chk("rst_beep", beep, 0);
    chk("rst_en", timer_enable, 0);
    chk("rst_clrn", timer_clrn, 0);
    clr = 0; step();
    chk("post_rst_clrn", timer_clrn, 1);

    // 1:20 -> 80 ticks, then randomized cook times and gaps.
    run_cook(3, 1, 2, 0, 1);
    for (int it = 0; it < 4; it++)
      run_cook($urandom_range(1, 3), $urandom_range(0, 1), $urandom_range(0, 5),
               $urandom_range(1, 9), $urandom_range(1, 3));

    // Zero time: start refused.
    press(0, 1, 1); press(0, 2, 1);
    start = 1; step(); start = 0;
    chk("zero_no_start", state, 1);
    chk("zero_no_mag", mag_on, 0);
    pulse_stop_to_idle();

    // Fourth digit and non-digit codes ignored.
    n = loads.size();
    press(5, 1, 1); press(12, 1, 0); press(9, 2, 1); press(9, 3, 1);
    press(7, 3, 0); press(15, 3, 0);
    chk("entry_state", state, 1);
    chk("three_loads", loads.size() - n, 3);
    pulse_stop_to_idle();

    // 0:05, door opened after 2 ticks.
    press(5, 1, 1);
    start = 1; step(); start = 0;
    tick_1hz = 1; #1;
    chk("en_open_gate", timer_enable, 1);
    step(); tick_1hz = 0; step();
    tick_1hz = 1; step(); tick_1hz = 0; step();
    chk("after_2_ticks", secs(), 3);
    door_closed = 0; tick_1hz = 1; #1;
    chk("en_door_gate", timer_enable, 0);
    step(); tick_1hz = 0;
    chk("door_paused", state, 3);
    chk("door_mag_off", mag_on, 0);
    for (int i = 0; i < 3; i++) begin tick_1hz = 1; step(); tick_1hz = 0; step(); end
    chk("paused_hold", secs(), 3);
    start = 1; step(); start = 0;
    chk("start_door_open", state, 3);
    door_closed = 1; start = 1; step(); start = 0;
    chk("resume_state", state, 2);
    chk("resume_mag", mag_on, 1);
    cook_ticks(1, n);
    chk("resume_ticks", n, 3);
    chk("resume_done", state, 4);
    // Key during DONE ends it early.
    press(4, 1, 1);
    chk("done_key_state", state, 1);
    chk("done_key_beep", beep, 0);
    pulse_stop_to_idle();

    // start+stop together in COOKING -> PAUSED, then stop -> IDLE.
    press(3, 1, 1); press(0, 2, 1);
    start = 1; step(); start = 0;
    for (int i = 0; i < 2; i++) begin tick_1hz = 1; step(); tick_1hz = 0; step(); end
    start = 1; stop = 1; tick_1hz = 1; #1;
    chk("en_stop_gate", timer_enable, 0);
    step(); start = 0; stop = 0; tick_1hz = 0;
    chk("ss_paused", state, 3);
    chk("ss_mag", mag_on, 0);
    chk("ss_hold", secs(), 28);
    pulse_stop_to_idle();

    // clr mid-cook at 1:00.
    press(1, 1, 1); press(0, 2, 1); press(0, 3, 1);
    start = 1; step(); start = 0;
    chk("c_cook", mag_on, 1);
    clr = 1; step();
    chk("clr_state", state, 0);
    chk("clr_mag", mag_on, 0);
    chk("clr_digits", digits, 0);
    chk("clr_loadn", timer_loadn, 1);
    chk("clr_clrn", timer_clrn, 0);
    clr = 0; step();
    chk("clr_timer", secs(), 0);

    // start in IDLE.
    n = loads.size();
    start = 1; step(); start = 0;
`ifdef QUICK_START_EN
    chk("qs_state", state, 5);
    chk("qs_load1", timer_data, 3);
    step();
    chk("qs_loadn2", timer_loadn, 0);
    chk("qs_load2", timer_data, 0);
    step();
    chk("qs_cook", state, 2);
    chk("qs_digits", digits, 2);
    chk("qs_secs", secs(), 30);
    chk("qs_loads", loads.size() - n, 2);
    stop = 1; step(); stop = 0;
    pulse_stop_to_idle();
`else
    chk("idle_start_state", state, 0);
    chk("idle_start_mag", mag_on, 0);
    step();
    chk("idle_start_loads", loads.size() - n, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/microwave_controller.md
# microwave_controller

Sequencing controller for the microwave's `timer` countdown datapath (three BCD digits: minutes, tens of seconds, ones of seconds).
- Turns debounced keypad, start, stop and door events into the timer's load, clear and enable controls, and drives the magnetron enable and the end-of-cook beep.
- Sits between the front-panel input conditioning and the `timer` instance.
- All inputs are already synchronous to `clock` and are single-cycle pulses unless noted.

## Interface
- `BEEP_CYCLES`, default 4: number of `clock` cycles `beep` stays high in DONE; minimum 1.
- `clock` input 1: single system clock, rising edge.
- `clr` input 1: synchronous, active-high reset.
- `tick_1hz` input 1: one-cycle pulse, once per second.
- `key_valid` input 1: one-cycle pulse, keypad key present.
- `key_code` input 4: key value; 0-9 are digits, 10-15 are ignored.
- `start` input 1: start/resume pulse.
- `stop` input 1: pause/cancel pulse.
- `door_closed` input 1: level, 1 = door closed.
- `timer_zero` input 1: `zero` output of the timer.
- `timer_data` output 4: digit presented to the timer's `data` input.
- `timer_loadn` output 1: active-low load/shift strobe to the timer.
- `timer_clrn` output 1: active-low clear to the timer.
- `timer_enable` output 1: countdown enable to the timer.
- `mag_on` output 1: magnetron enable.
- `beep` output 1: end-of-cook indicator.
- `state` output 3: current state encoding, for display and debug.
- `digits` output 2: number of digits entered, 0-3.

## Operation
State encoding: IDLE=0, ENTRY=1, COOKING=2, PAUSED=3, DONE=4, QLOAD=5. QLOAD exists only with the macro defined.

**Key entry**
- A valid digit key (`key_valid` and `key_code`<=9) is accepted in IDLE, ENTRY or DONE, and only while `digits`<3.
- On acceptance: `timer_loadn`=0 for exactly one cycle, with `timer_data`=`key_code`. The timer then shifts ones→tens→minutes and takes the new digit into ones.
- On acceptance: `digits` increments and the state becomes ENTRY.
- Ignored keys: 4th and later digits, and codes 10-15. They cause no load and no state change.
- Key entry during DONE ends DONE early: `beep` drops and the key is accepted.

**Transitions**
- ENTRY + `start` + `door_closed` + !`timer_zero` → COOKING. If `timer_zero`=1 (e.g. "0","0" entered), stay in ENTRY.
- ENTRY + `stop` → IDLE, with a one-cycle timer clear.
- COOKING:
  - `mag_on`=1.
  - `timer_enable` = `tick_1hz` & `door_closed` & !`stop`. This is a combinational gate, so a cancelled second is never decremented.
  - `timer_zero`=1 → DONE.
  - Else `stop` or !`door_closed` → PAUSED.
- PAUSED:
  - `stop` → IDLE with a timer clear.
  - Else `start` & `door_closed` → COOKING.
  - Timer contents are held.
- DONE: `beep`=1 for `BEEP_CYCLES` cycles, then IDLE. `stop` → IDLE immediately. `digits` is reset to 0 on entry.
- IDLE + `start`, macro undefined: ignored.

**Priority (same cycle)**
- `clr` > `timer_zero` (in COOKING) > `stop` > door open > `start` > key.
- `start` and `stop` together: stop wins.

**Timer clear**
- `timer_clrn`=0 for one cycle on every transition to IDLE from ENTRY or PAUSED, and on every cycle `clr`=1.
- After a clear, `digits` is 0.

## Timing
- Reset (`clr`=1 at a rising edge), next-cycle values:
  - state=IDLE, `digits`=0, `timer_data`=0, `timer_loadn`=1, `mag_on`=0, `beep`=0, `timer_enable`=0.
  - `timer_clrn`=0 combinationally while `clr`=1.
  - Reset mid-cook stops the magnetron on the next edge.
- Registered outputs: `state`, `digits`, `timer_data`, `timer_loadn`, `mag_on`, `beep`. Registered `timer_clrn` pulses are ANDed with !`clr`.
- Only `timer_enable` is combinational.
- Key-to-load latency: `key_valid` at edge N → `timer_loadn`=0 during cycle N+1 → digit in the timer after edge N+2.
- `start` at edge N → state=COOKING and `mag_on`=1 after edge N+1. The first decrement occurs on the first `tick_1hz` after that.
- `timer_zero` sampled in COOKING at edge N → `mag_on`=0 and `beep`=1 after edge N+1.
- Door opening: `mag_on` falls one cycle later. `timer_enable` is gated in the same cycle.

## Configuration
- `QUICK_START_EN` defined:
  - IDLE + `start` + `door_closed` → QLOAD.
  - QLOAD issues two consecutive `timer_loadn` pulses: data 3, then data 0. This loads 0:30.
  - Then state goes to COOKING and `digits` is set to 2. Cooking begins 3 cycles after the `start` edge.
  - `stop` in QLOAD is ignored until COOKING.
- `QUICK_START_EN` undefined: `start` in IDLE is ignored, and state 5 is unreachable.

## Test plan
- Key 1, 2, 0 with door closed, then `start`:
  - Three `timer_loadn` pulses, data 1/2/0.
  - COOKING with `mag_on`=1.
  - After 80 ticks, `timer_zero` → DONE, `beep` high for 4 cycles, then IDLE.
- Keys 5, 9, 9, 7:
  - Only three load pulses; `digits`=3.
  - The 4th key produces no strobe.
  - `key_code`=12 produces no strobe.
- Cooking at 0:05:
  - Open the door after 2 ticks → PAUSED, `mag_on`=0, timer holds 0:03 across further ticks.
  - Close the door and pulse `start` → resumes to zero.
- `start` and `stop` in the same cycle during COOKING → PAUSED.
- `stop` again → `timer_clrn` low for one cycle, IDLE, `digits`=0.
- Assert `clr` mid-cook at 1:00 → all outputs at reset values on the next edge, `timer_clrn`=0.
- With `QUICK_START_EN`: `start` in IDLE → loads 3 then 0, COOKING from 0:30. Without it: no change.
